// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter.
//   regval_t    : 32-bit register/memory word
//   arb_state_t : arbiter FSM state
//   grant_t     : identifies requester A (instruction) or B (data)
package memory_arbiter_pkg;

  typedef logic [31:0] regval_t;

  typedef enum logic [1:0] {
    StIdle,
    StServeA,
    StServeB,
    StDrain
  } arb_state_t;

  typedef enum logic {
    GrantA,
    GrantB
  } grant_t;

endpackage

// File: rtl/i_cache.sv
// Requester-side bus of the memory arbiter.
//   address_enable : level read request, held until data_valid
//   address        : read address, stable while address_enable is high
//   data_valid     : one-cycle response strobe to the requester
//   data           : response data, meaningful with data_valid
// Modport impl is the arbiter side, client is the requester side.
interface i_cache;

  logic                        address_enable;
  memory_arbiter_pkg::regval_t address;
  logic                        data_valid;
  memory_arbiter_pkg::regval_t data;

  modport impl (
    input  address_enable,
    input  address,
    output data_valid,
    output data
  );

  modport client (
    output address_enable,
    output address,
    input  data_valid,
    input  data
  );

endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory read port between two requesters.
//   clock, reset_n        : clock, asynchronous active-low reset
//   mem_address_enable    : memory read request, held until response or timeout
//   mem_address           : memory read address
//   mem_data_valid        : memory response strobe
//   mem_data              : memory response data
//   a, b                  : requester ports (A instruction side, B data side)
//   timeout               : one-cycle pulse when a memory request is abandoned
//   busy                  : high whenever the arbiter is not idle
// TIMEOUT is the response limit in cycles; 0 disables it. The timeout pulse is
// raised in the TIMEOUT-th cycle of a state, unless a response arrives then.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic       mem_address_enable,
  output regval_t    mem_address,
  input  logic       mem_data_valid,
  input  regval_t    mem_data,
  i_cache.impl       a,
  i_cache.impl       b,
  output logic       timeout,
  output logic       busy
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLimit = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t      state_q, state_d;
  grant_t          last_grant_q, last_grant_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  regval_t         addr_q, addr_d;
  grant_t          pick;
  logic            serve_req;
  logic            limit_hit;

  function automatic grant_t rr_pick(input logic req_a, input logic req_b, input grant_t last);
    if (req_a && req_b) begin
      return (last == GrantB) ? GrantA : GrantB;
    end
    return req_a ? GrantA : GrantB;
  endfunction

  assign limit_hit = (TIMEOUT != 0) && (cnt_q == CntLimit);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    pick         = GrantA;
    serve_req    = 1'b0;
    timeout      = 1'b0;
    a.data_valid = 1'b0;
    b.data_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        // last_grant is only consulted here, so updating it at grant time is
        // equivalent to updating it when the service completes.
        if (a.address_enable || b.address_enable) begin
          pick         = rr_pick(a.address_enable, b.address_enable, last_grant_q);
          state_d      = (pick == GrantA) ? StServeA : StServeB;
          addr_d       = (pick == GrantA) ? a.address : b.address;
          last_grant_d = pick;
        end
      end
      StServeA, StServeB: begin
        serve_req = (state_q == StServeA) ? a.address_enable : b.address_enable;
        if (mem_data_valid) begin
          // A response that meets a just-dropped request is simply consumed.
          state_d = StIdle;
          if (state_q == StServeA) begin
            a.data_valid = serve_req;
          end else begin
            b.data_valid = serve_req;
          end
        end else if (limit_hit) begin
          timeout = 1'b1;
          state_d = StIdle;
        end else if (!serve_req) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (mem_data_valid) begin
          state_d = StIdle;
        end else if (limit_hit) begin
          timeout = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Cleared on every state entry, saturating while serving or draining.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q != StIdle && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      last_grant_q <= GrantB;
      cnt_q        <= '0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
    end
  end

  assign mem_address_enable = (state_q != StIdle);
  assign busy               = (state_q != StIdle);

  // The live address is forwarded while serving; DRAIN keeps the grant-time copy.
  always_comb begin
    mem_address = addr_q;
    if (state_q == StServeA) begin
      mem_address = a.address;
    end else if (state_q == StServeB) begin
      mem_address = b.address;
    end
  end

  assign a.data = mem_data;
  assign b.data = mem_data;

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int unsigned TO = 4;

  logic    clock;
  logic    reset_n;
  logic    mem_address_enable;
  regval_t mem_address;
  logic    mem_data_valid;
  regval_t mem_data;
  logic    timeout;
  logic    busy;

  i_cache a_if ();
  i_cache b_if ();

  memory_arbiter #(
    .TIMEOUT (TO)
  ) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .mem_address_enable (mem_address_enable),
    .mem_address        (mem_address),
    .mem_data_valid     (mem_data_valid),
    .mem_data           (mem_data),
    .a                  (a_if),
    .b                  (b_if),
    .timeout            (timeout),
    .busy               (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the memory port, whether the owner gave up,
  // how many cycles have passed in the current phase, and who was served last.
  int      m_owner;    // -1 none, 0 A, 1 B
  bit      m_drain;
  int      m_elapsed;
  int      m_last;
  regval_t m_lat;
  bit      exp_dv_a, exp_dv_b;

  task automatic model_reset();
    m_owner   = -1;
    m_drain   = 1'b0;
    m_elapsed = 0;
    m_last    = 1;
    m_lat     = '0;
  endtask

  // One clock cycle: drive inputs mid-cycle, check outputs, advance the model.
  task automatic step(input logic ra, input regval_t aa, input logic rb, input regval_t ab,
                      input logic mdv, input regval_t md);
    bit hit;
    bit own_req;
    @(negedge clock);
    a_if.address_enable = ra;
    a_if.address        = aa;
    b_if.address_enable = rb;
    b_if.address        = ab;
    mem_data_valid      = mdv;
    mem_data            = md;
    #1;
    hit      = (m_owner >= 0) && (m_elapsed == int'(TO) - 1) && !mdv;
    exp_dv_a = (m_owner == 0) && !m_drain && mdv && ra;
    exp_dv_b = (m_owner == 1) && !m_drain && mdv && rb;
    check_eq("busy", 32'(busy), 32'(m_owner >= 0));
    check_eq("mem_en", 32'(mem_address_enable), 32'(m_owner >= 0));
    if (m_owner >= 0) begin
      check_eq("mem_addr", mem_address, m_drain ? m_lat : ((m_owner == 0) ? aa : ab));
    end
    check_eq("dv_a", 32'(a_if.data_valid), 32'(exp_dv_a));
    check_eq("dv_b", 32'(b_if.data_valid), 32'(exp_dv_b));
    check_eq("timeout", 32'(timeout), 32'(hit));
    check_eq("data_a", a_if.data, md);
    check_eq("data_b", b_if.data, md);
    if (m_owner < 0) begin
      if (ra || rb) begin
        m_owner   = (ra && rb) ? 1 - m_last : (ra ? 0 : 1);
        m_lat     = (m_owner == 0) ? aa : ab;
        m_drain   = 1'b0;
        m_elapsed = 0;
      end
    end else begin
      own_req = (m_owner == 0) ? ra : rb;
      if (mdv || hit) begin
        m_last  = m_owner;
        m_owner = -1;
      end else if (!m_drain && !own_req) begin
        m_drain   = 1'b1;
        m_elapsed = 0;
      end else begin
        m_elapsed++;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_mem_en"}, 32'(mem_address_enable), 32'd0);
    check_eq({tag, "_timeout"}, 32'(timeout), 32'd0);
    check_eq({tag, "_dv_a"}, 32'(a_if.data_valid), 32'd0);
    check_eq({tag, "_dv_b"}, 32'(b_if.data_valid), 32'd0);
    check_eq({tag, "_addr"}, mem_address, 32'd0);
  endtask

  // Random requesters: level requests held until served, occasional abort.
  bit      ca_req, cb_req;
  regval_t ca_addr, cb_addr;

  task automatic rand_cycle();
    logic    mdv;
    regval_t md;
    if (!ca_req && $urandom_range(99) < 40) begin
      ca_req  = 1'b1;
      ca_addr = $urandom;
    end else if (ca_req && $urandom_range(99) < 4) begin
      ca_req = 1'b0;
    end
    if (!cb_req && $urandom_range(99) < 40) begin
      cb_req  = 1'b1;
      cb_addr = $urandom;
    end else if (cb_req && $urandom_range(99) < 4) begin
      cb_req = 1'b0;
    end
    mdv = ($urandom_range(99) < 30);
    md  = $urandom;
    step(ca_req, ca_addr, cb_req, cb_addr, mdv, md);
    if (exp_dv_a) ca_req = 1'b0;
    if (exp_dv_b) cb_req = 1'b0;
  endtask

  initial begin
    int order[4];
    int n_served;
    int n_to;

    reset_n             = 1'b0;
    a_if.address_enable = 1'b0;
    a_if.address        = '0;
    b_if.address_enable = 1'b0;
    b_if.address        = '0;
    mem_data_valid      = 1'b0;
    mem_data            = '0;
    model_reset();
    #2;
    check_reset_outputs("rst");
    @(negedge clock);
    reset_n = 1'b1;

    // Simultaneous requests twice: deliveries must alternate A, B, A, B.
    ca_req = 1'b1; ca_addr = 32'hA000_0001;
    cb_req = 1'b1; cb_addr = 32'hB000_0001;
    n_served = 0;
    for (int i = 0; i < 4; i++) order[i] = -1;
    for (int cyc = 0; cyc < 30 && n_served < 4; cyc++) begin
      step(ca_req, ca_addr, cb_req, cb_addr, 1'b1, 32'h1234_0000 + 32'(cyc));
      if (exp_dv_a) begin order[n_served] = 0; n_served++; ca_req = 1'b0; end
      if (exp_dv_b) begin order[n_served] = 1; n_served++; cb_req = 1'b0; end
      if (!ca_req && !cb_req && n_served == 2) begin
        ca_req = 1'b1; ca_addr = 32'hA000_0002;
        cb_req = 1'b1; cb_addr = 32'hB000_0002;
      end
    end
    check_eq("rr_order0", 32'(order[0]), 32'd0);
    check_eq("rr_order1", 32'(order[1]), 32'd1);
    check_eq("rr_order2", 32'(order[2]), 32'd0);
    check_eq("rr_order3", 32'(order[3]), 32'd1);
    ca_req = 1'b0; cb_req = 1'b0;
    step(0, '0, 0, '0, 0, '0);

    // A reads 0x100, answer in the fourth serve cycle (also the TIMEOUT-th).
    step(1, 32'h100, 0, '0, 0, '0);
    for (int i = 0; i < 3; i++) step(1, 32'h100, 0, '0, 0, '0);
    step(1, 32'h100, 0, '0, 1, 32'hDEAD_BEEF);
    check_eq("a_delivered", 32'(exp_dv_a), 32'd1);
    step(0, '0, 0, '0, 0, '0);

    // B reads 0x200 and aborts; late response is swallowed by DRAIN.
    step(0, '0, 1, 32'h200, 0, '0);
    step(0, '0, 1, 32'h200, 0, '0);
    step(0, '0, 0, '0, 0, '0);
    step(0, '0, 0, '0, 0, '0);
    step(0, '0, 0, '0, 0, '0);
    step(0, '0, 0, '0, 1, 32'h5555_AAAA);
    step(0, '0, 0, '0, 0, '0);
    check_eq("drain_idle", 32'(busy), 32'd0);

    // A never answered: one timeout pulse, then A is re-granted.
    n_to = 0;
    for (int i = 0; i < 7; i++) begin
      step(1, 32'h300, 0, '0, 0, '0);
      if (timeout) n_to++;
    end
    check_eq("timeout_once", 32'(n_to), 32'd1);
    check_eq("regrant_a", mem_address, 32'h300);
    step(1, 32'h300, 0, '0, 1, 32'h0BAD_F00D);
    step(0, '0, 0, '0, 0, '0);

    // Reset in the middle of serving B.
    step(0, '0, 1, 32'h400, 0, '0);
    step(0, '0, 1, 32'h400, 0, '0);
    @(negedge clock);
    mem_data_valid = 1'b1;
    mem_data       = 32'h7777_7777;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    b_if.address_enable = 1'b0;
    mem_data_valid      = 1'b0;
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    step(0, '0, 0, '0, 1, 32'h8888_8888);
    check_eq("late_rsp_b", 32'(b_if.data_valid), 32'd0);

    ca_req = 1'b0; cb_req = 1'b0;
    for (int i = 0; i < 800; i++) rand_cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
